// File: rtl/core_ex_wbck.sv
// core_ex_wbck: write-back arbiter and pending-destination scoreboard.
// Two completion sources feed the register file write port. Load data from
// the LSU always wins over the single-cycle ALU. The write port is registered,
// so a result reaches it one cycle after its handshake. The scoreboard records
// long-latency destinations and answers RAW/WAW hazard queries for issue.
// A query also hits the destination that is sitting in the write-port
// register and has not reached the register file yet.
module core_ex_wbck #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int RF_NUM  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_valid,
  output logic               alu_wbck_ready,
  input  logic               alu_wbck_en,
  input  logic [RFIDX_W-1:0] alu_wbck_idx,
  input  logic [XLEN-1:0]    alu_wbck_dat,
  input  logic               lsu_wbck_valid,
  output logic               lsu_wbck_ready,
  input  logic [RFIDX_W-1:0] lsu_wbck_idx,
  input  logic [XLEN-1:0]    lsu_wbck_dat,
  input  logic               lng_issue,
  input  logic [RFIDX_W-1:0] lng_issue_idx,
  input  logic [RFIDX_W-1:0] chk_src1_idx,
  input  logic [RFIDX_W-1:0] chk_src2_idx,
  input  logic [RFIDX_W-1:0] chk_dest_idx,
  output logic               chk_hazard,
  output logic [RF_NUM-1:0]  pend_vec,
  output logic               wb_dest_wen,
  output logic [RFIDX_W-1:0] wb_dest_idx,
  output logic [XLEN-1:0]    wb_dest_dat
);

  logic               lsu_hs_s;
  logic               alu_hs_s;
  logic               wen_r;
  logic [RFIDX_W-1:0] idx_r;
  logic [XLEN-1:0]    dat_r;
  logic [RF_NUM-1:0]  pend_r;
  logic [RF_NUM-1:0]  pend_nxt_s;
  logic               pend_hit_s;
  logic               wb_hit_s;

  // The LSU has fixed priority: it is always ready, and the ALU waits while load data is offered
  assign lsu_wbck_ready = 1'b1;
  assign alu_wbck_ready = ~lsu_wbck_valid;
  assign lsu_hs_s       = lsu_wbck_valid;
  assign alu_hs_s       = alu_wbck_valid & ~lsu_wbck_valid;

  // Write-port register: the winning handshake loads idx/dat, and wen drops when there is no handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_r <= 1'b0;
      idx_r <= {RFIDX_W{1'b0}};
      dat_r <= {XLEN{1'b0}};
    end else if (lsu_hs_s) begin
      wen_r <= (lsu_wbck_idx != {RFIDX_W{1'b0}});
      idx_r <= lsu_wbck_idx;
      dat_r <= lsu_wbck_dat;
    end else if (alu_hs_s) begin
      wen_r <= alu_wbck_en & (alu_wbck_idx != {RFIDX_W{1'b0}});
      idx_r <= alu_wbck_idx;
      dat_r <= alu_wbck_dat;
    end else begin
      wen_r <= 1'b0;
      idx_r <= idx_r;
      dat_r <= dat_r;
    end
  end

  // Scoreboard next state: a new issue wins over a same-cycle load clear, and x0 is never pending
  always_comb begin
    pend_nxt_s = pend_r;
    for (int i = 1; i < RF_NUM; i++) begin
      if (lng_issue && (lng_issue_idx == RFIDX_W'(i))) begin
        pend_nxt_s[i] = 1'b1;
      end else if (lsu_hs_s && (lsu_wbck_idx == RFIDX_W'(i))) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {RF_NUM{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Hazard query: a pending long op, or a write that is still in the write-port register
  always_comb begin
    pend_hit_s = pend_r[chk_src1_idx] | pend_r[chk_src2_idx] | pend_r[chk_dest_idx];
    if (wen_r && (idx_r != {RFIDX_W{1'b0}})) begin
      wb_hit_s = (idx_r == chk_src1_idx) | (idx_r == chk_src2_idx) | (idx_r == chk_dest_idx);
    end else begin
      wb_hit_s = 1'b0;
    end
  end

  assign chk_hazard  = pend_hit_s | wb_hit_s;
  assign pend_vec    = pend_r;
  assign wb_dest_wen = wen_r;
  assign wb_dest_idx = idx_r;
  assign wb_dest_dat = dat_r;

endmodule

// File: tb/tb_core_ex_wbck.sv
// tb_core_ex_wbck: table-driven write-back vectors checked through an
// expected-write queue, plus hand-written scoreboard, hazard and reset sequences.
module tb_core_ex_wbck;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;
  localparam int RF_NUM  = 32;

  logic               clk;
  logic               rst_n;
  logic               alu_wbck_valid;
  logic               alu_wbck_ready;
  logic               alu_wbck_en;
  logic [RFIDX_W-1:0] alu_wbck_idx;
  logic [XLEN-1:0]    alu_wbck_dat;
  logic               lsu_wbck_valid;
  logic               lsu_wbck_ready;
  logic [RFIDX_W-1:0] lsu_wbck_idx;
  logic [XLEN-1:0]    lsu_wbck_dat;
  logic               lng_issue;
  logic [RFIDX_W-1:0] lng_issue_idx;
  logic [RFIDX_W-1:0] chk_src1_idx;
  logic [RFIDX_W-1:0] chk_src2_idx;
  logic [RFIDX_W-1:0] chk_dest_idx;
  logic               chk_hazard;
  logic [RF_NUM-1:0]  pend_vec;
  logic               wb_dest_wen;
  logic [RFIDX_W-1:0] wb_dest_idx;
  logic [XLEN-1:0]    wb_dest_dat;

  core_ex_wbck #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .RF_NUM(RF_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_en(alu_wbck_en), .alu_wbck_idx(alu_wbck_idx), .alu_wbck_dat(alu_wbck_dat),
    .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
    .lsu_wbck_idx(lsu_wbck_idx), .lsu_wbck_dat(lsu_wbck_dat),
    .lng_issue(lng_issue), .lng_issue_idx(lng_issue_idx),
    .chk_src1_idx(chk_src1_idx), .chk_src2_idx(chk_src2_idx), .chk_dest_idx(chk_dest_idx),
    .chk_hazard(chk_hazard), .pend_vec(pend_vec),
    .wb_dest_wen(wb_dest_wen), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               wen;
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
  } wr_t;

  typedef struct {
    logic               alu_v;
    logic               alu_en;
    logic [RFIDX_W-1:0] alu_idx;
    logic [XLEN-1:0]    alu_dat;
    logic               lsu_v;
    logic [RFIDX_W-1:0] lsu_idx;
    logic [XLEN-1:0]    lsu_dat;
    logic               exp_ready;
    logic               exp_wen;
    logic [RFIDX_W-1:0] exp_idx;
    logic [XLEN-1:0]    exp_dat;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: apply inputs, check the arbitration outputs, queue the expected write, then check it after the edge
  task automatic drive(input logic av, input logic aen, input logic [RFIDX_W-1:0] aidx,
                       input logic [XLEN-1:0] adat, input logic lv, input logic [RFIDX_W-1:0] lidx,
                       input logic [XLEN-1:0] ldat, input logic li, input logic [RFIDX_W-1:0] liidx,
                       input logic eready, input logic ewen, input logic [RFIDX_W-1:0] eidx,
                       input logic [XLEN-1:0] edat);
    wr_t w;
    alu_wbck_valid = av;  alu_wbck_en = aen; alu_wbck_idx = aidx; alu_wbck_dat = adat;
    lsu_wbck_valid = lv;  lsu_wbck_idx = lidx; lsu_wbck_dat = ldat;
    lng_issue = li; lng_issue_idx = liidx;
    #1;
    chk("alu_ready", {63'd0, alu_wbck_ready}, {63'd0, eready});
    chk("lsu_ready", {63'd0, lsu_wbck_ready}, 64'd1);
    w.wen = ewen; w.idx = eidx; w.dat = edat;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    alu_wbck_valid = 1'b0; lsu_wbck_valid = 1'b0; lng_issue = 1'b0;
    w = exp_q.pop_front();
    chk("wb_wen", {63'd0, wb_dest_wen}, {63'd0, w.wen});
    chk("wb_idx", {59'd0, wb_dest_idx}, {59'd0, w.idx});
    chk("wb_dat", {32'd0, wb_dest_dat}, {32'd0, w.dat});
  endtask

  task automatic idle(input logic [RFIDX_W-1:0] hidx, input logic [XLEN-1:0] hdat);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, hidx, hdat);
  endtask

  task automatic hz(input logic [RFIDX_W-1:0] s1, input logic [RFIDX_W-1:0] s2,
                    input logic [RFIDX_W-1:0] d, input logic exp, input string name);
    chk_src1_idx = s1; chk_src2_idx = s2; chk_dest_idx = d;
    #1;
    chk(name, {63'd0, chk_hazard}, {63'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    alu_wbck_valid = 1'b0; alu_wbck_en = 1'b0; alu_wbck_idx = 5'd0; alu_wbck_dat = 32'd0;
    lsu_wbck_valid = 1'b0; lsu_wbck_idx = 5'd0; lsu_wbck_dat = 32'd0;
    lng_issue = 1'b0; lng_issue_idx = 5'd0;
    chk_src1_idx = 5'd0; chk_src2_idx = 5'd0; chk_dest_idx = 5'd0;

    // Table: {alu_v, en, idx, dat, lsu_v, idx, dat, exp_ready, exp_wen, exp_idx, exp_dat}
    vecs[0] = '{1'b1, 1'b1, 5'd3,  32'h11, 1'b1, 5'd7,  32'h22, 1'b0, 1'b1, 5'd7,  32'h22};
    vecs[1] = '{1'b1, 1'b1, 5'd3,  32'h11, 1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd3,  32'h11};
    vecs[2] = '{1'b1, 1'b0, 5'd8,  32'h33, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd8,  32'h33};
    vecs[3] = '{1'b1, 1'b1, 5'd0,  32'h44, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd0,  32'h44};
    vecs[4] = '{1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd0,  32'h55, 1'b0, 1'b0, 5'd0,  32'h55};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 1'b1, 5'd1,  32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd1, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd1,  32'hA5A5A5A5};

    // Reset state
    #12;
    chk("rst_wen", {63'd0, wb_dest_wen}, 64'd0);
    chk("rst_idx", {59'd0, wb_dest_idx}, 64'd0);
    chk("rst_dat", {32'd0, wb_dest_dat}, 64'd0);
    chk("rst_pend", {32'd0, pend_vec}, 64'd0);
    hz(5'd0, 5'd0, 5'd0, 1'b0, "rst_hazard");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU write, then wen drops while idx/dat hold
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    idle(5'd5, 32'hDEADBEEF);

    // Table-driven arbitration vectors
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].alu_v, vecs[i].alu_en, vecs[i].alu_idx, vecs[i].alu_dat,
            vecs[i].lsu_v, vecs[i].lsu_idx, vecs[i].lsu_dat, 1'b0, 5'd0,
            vecs[i].exp_ready, vecs[i].exp_wen, vecs[i].exp_idx, vecs[i].exp_dat);
    end
    chk("pend_after_tbl", {32'd0, pend_vec}, 64'd0);

    // Long op to x9: pending, then cleared by its load, hazard lingers one cycle via write port
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 32'hA5A5A5A5);
    chk("pend_set9", {32'd0, pend_vec}, 64'h200);
    hz(5'd9, 5'd0, 5'd0, 1'b1, "hz_src1_9");
    hz(5'd10, 5'd0, 5'd0, 1'b0, "hz_other");
    hz(5'd9, 5'd0, 5'd0, 1'b1, "hz_src1_9b");
    idle(5'd1, 32'hA5A5A5A5);
    chk("pend_hold9", {32'd0, pend_vec}, 64'h200);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h99);
    chk("pend_clr9", {32'd0, pend_vec}, 64'd0);
    hz(5'd9, 5'd0, 5'd0, 1'b1, "hz_wb_window");
    idle(5'd9, 32'h99);
    hz(5'd9, 5'd0, 5'd0, 1'b0, "hz_after_wb");

    // Two pending bits; src2 and dest queries; clearing one leaves the other
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b1, 1'b0, 5'd9, 32'h99);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b1, 1'b0, 5'd9, 32'h99);
    chk("pend_12_20", {32'd0, pend_vec}, 64'h0010_1000);
    hz(5'd0, 5'd12, 5'd0, 1'b1, "hz_src2");
    hz(5'd0, 5'd0, 5'd20, 1'b1, "hz_dest");
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20, 32'h20);
    chk("pend_clr20", {32'd0, pend_vec}, 64'h0000_1000);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h12, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 32'h12);
    chk("pend_clr12", {32'd0, pend_vec}, 64'd0);

    // Same-cycle issue and clear of x4: set wins
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 1'b0, 5'd12, 32'h12);
    chk("pend_set4", {32'd0, pend_vec}, 64'h10);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 1'b0, 1'b1, 5'd4, 32'h44);
    chk("pend_set_wins", {32'd0, pend_vec}, 64'h10);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 32'h45);
    chk("pend_clr4", {32'd0, pend_vec}, 64'd0);

    // Index 0: issue leaves the scoreboard untouched, all-zero query never hazards
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd4, 32'h45);
    chk("pend_idx0", {32'd0, pend_vec}, 64'd0);
    hz(5'd0, 5'd0, 5'd0, 1'b0, "hz_idx0");

    // Asynchronous reset in the middle of a write with a bit pending
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 1'b1, 1'b0, 5'd4, 32'h45);
    drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd6, 32'h66);
    chk("pend_pre_rst", {32'd0, pend_vec}, 64'h8000);
    rst_n = 1'b0;
    #1;
    chk("arst_wen", {63'd0, wb_dest_wen}, 64'd0);
    chk("arst_idx", {59'd0, wb_dest_idx}, 64'd0);
    chk("arst_dat", {32'd0, wb_dest_dat}, 64'd0);
    chk("arst_pend", {32'd0, pend_vec}, 64'd0);
    rst_n = 1'b1;

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_ex_wbck.md
Name: core_ex_wbck

Overview:
- Write-back arbiter and scoreboard: the writer side of the integer register file. It drives the regfile write port (wb_dest_wen/idx/dat) from two completion sources:
  - the single-cycle ALU;
  - the long-latency LSU (loads).
- It tracks destinations of issued long-latency ops in a pending scoreboard. Issue logic uses the scoreboard for RAW/WAW stall decisions.
- Sits between the EX/LSU completion paths and core_ex_regfile.

Parameters:
XLEN, 32, data width (matches CORE_XLEN)
RFIDX_W, 5, register index width (matches CORE_RFIDX_WIDTH)
RF_NUM, 32, number of architectural registers

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
alu_wbck_valid  input  1  ALU result available
alu_wbck_ready  output  1  ALU result accepted this cycle
alu_wbck_en  input  1  result must be written (0 for branches/stores)
alu_wbck_idx  input  RFIDX_W  ALU destination index
alu_wbck_dat  input  XLEN  ALU result
lsu_wbck_valid  input  1  load data available
lsu_wbck_ready  output  1  load data accepted this cycle
lsu_wbck_idx  input  RFIDX_W  load destination index
lsu_wbck_dat  input  XLEN  load data
lng_issue  input  1  long op issued this cycle (pulse)
lng_issue_idx  input  RFIDX_W  destination of issued long op
chk_src1_idx  input  RFIDX_W  hazard query, source 1
chk_src2_idx  input  RFIDX_W  hazard query, source 2
chk_dest_idx  input  RFIDX_W  hazard query, destination
chk_hazard  output  1  any queried index pending
pend_vec  output  RF_NUM  scoreboard contents
wb_dest_wen  output  1  regfile write enable
wb_dest_idx  output  RFIDX_W  regfile write index
wb_dest_dat  output  XLEN  regfile write data

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous, active-low on rst_n. All state is cleared on reset.
- Reset values: wb_dest_wen=0, wb_dest_idx=0, wb_dest_dat=0, pend_vec=0.
- Reset mid-operation: in-flight output and all pending bits are discarded. Upstream must also be reset.
- Arbitration (combinational):
  - lsu_wbck_ready = 1 always.
  - alu_wbck_ready = ~lsu_wbck_valid. LSU has fixed priority.
  - An ALU valid held while an LSU valid is present stalls. ALU valid/idx/dat must stay stable until the handshake completes.
- Output register:
  - On each edge, the winning handshake loads wb_dest_idx/dat.
  - wb_dest_wen is loaded as follows:
    - LSU winner: (lsu_wbck_idx != 0).
    - ALU winner: alu_wbck_en & (alu_wbck_idx != 0).
  - With no handshake, wb_dest_wen is 0 next cycle. idx/dat hold their values.
  - Latency: 1 cycle from handshake to write-port assertion. The write lands in the regfile on the following edge.
  - A handshake with idx 0 completes normally, but no write is issued.
- Scoreboard, pend_vec[i] per register:
  - set: lng_issue & lng_issue_idx==i & i!=0.
  - clr: LSU handshake & lsu_wbck_idx==i.
  - If set and clr for the same i occur in one cycle, set wins: the new op is outstanding.
  - Issue to an already-pending index leaves the bit at 1. Issue logic must not do this; it is guarded by chk_hazard on chk_dest_idx.
  - pend_vec[0] is constant 0.
- Hazard query (combinational):
  - chk_hazard = pend_vec[chk_src1_idx] | pend_vec[chk_src2_idx] | pend_vec[chk_dest_idx].
  - It also asserts if wb_dest_wen=1 and wb_dest_idx equals any nonzero queried index. This covers the not-yet-written window.
  - Index 0 queries never hazard.
- Simultaneous events:
  - Both valid: LSU is accepted and ALU stalls.
  - An LSU clear and the output register update happen in the same edge. The hazard then persists one more cycle through the wb_dest term.

Test Plan:
- Reset, then idle: all outputs 0, pend_vec=0. Assert rst_n low mid-write: wb_dest_wen drops to 0 immediately (asynchronous).
- ALU valid, idx=5, dat=0xDEADBEEF, en=1 → alu_wbck_ready=1 same cycle. Next cycle wen=1, idx=5, dat=0xDEADBEEF. Cycle after that, wen=0.
- ALU and LSU valid together (ALU idx=3/0x11, LSU idx=7/0x22):
  - Cycle 1: LSU wins, ALU ready=0. Next cycle writes 7/0x22.
  - The following cycle writes 3/0x11.
- lng_issue idx=9:
  - Next cycle pend_vec[9]=1, and chk_hazard=1 for chk_src1_idx=9.
  - After the LSU handshake idx=9: bit clears next edge. chk_hazard stays 1 one more cycle via wb_dest, then 0.
- Same-cycle lng_issue idx=4 and LSU handshake idx=4 with pend_vec[4]=1 → pend_vec[4] remains 1.
- Index 0 cases:
  - ALU idx=0, en=1 → handshake completes, wen stays 0.
  - lng_issue idx=0 → pend_vec unchanged.
  - chk all idx=0 → chk_hazard=0.
